// File: rtl/mtl_scan_timing_pkg.sv
// Shared panel constants, coordinate widths and the sync strobe bundle for
// the MTL raster scan path.
package mtl_timing_pkg;

  localparam int X_W = 11;
  localparam int Y_W = 10;

  localparam int DEF_H_ACTIVE = 800;
  localparam int DEF_H_FP     = 210;
  localparam int DEF_H_SYNC   = 30;
  localparam int DEF_H_BP     = 16;
  localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;

  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 22;
  localparam int DEF_V_SYNC   = 13;
  localparam int DEF_V_BP     = 10;
  localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  typedef struct packed {
    logic hs_n;
    logic vs_n;
    logic de;
  } sync_t;

  localparam sync_t SYNC_IDLE = '{hs_n: 1'b1, vs_n: 1'b1, de: 1'b0};

endpackage

// File: rtl/mtl_scan_timing_if.sv
// Scan bus: enable from the consumer side, coordinates and strobes from the
// timing generator.
interface mtl_scan_if;
  import mtl_timing_pkg::*;

  logic           en;
  logic [X_W-1:0] x_cnt;
  logic [Y_W-1:0] y_cnt;
  logic           line_start;
  logic           frame_start;
  logic           hsync_n;
  logic           vsync_n;
  logic           de;

  modport master (
    input  en,
    output x_cnt, y_cnt, line_start, frame_start, hsync_n, vsync_n, de
  );

  modport slave (
    output en,
    input  x_cnt, y_cnt, line_start, frame_start, hsync_n, vsync_n, de
  );

endinterface

// File: rtl/mtl_scan_timing_sync_delay.sv
// DEPTH-stage shift register for the sync strobes; stages idle inactive on
// reset and hold while the scan is frozen.
module sync_delay
  import mtl_timing_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  en_i,
  input  sync_t din_i,
  output sync_t dout_o
);

  sync_t stage_q [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= SYNC_IDLE;
    end else if (en_i) begin
      stage_q[0] <= din_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign dout_o = stage_q[DEPTH-1];

endmodule

// File: rtl/mtl_scan_timing.sv
// Raster scan generator: pixel coordinates plus sync/DE strobes delayed to
// line up with the registered colour outputs of downstream generators.
module mtl_scan_timing
  import mtl_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int PIPE_DLY = 1
) (
  input  logic        clk,
  input  logic        reset,
  mtl_scan_if.master  bus
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 2047 || V_TOTAL > 1023) begin : g_bad_total
    $error("mtl_scan_timing: H_TOTAL/V_TOTAL exceed coordinate widths");
  end
  if (PIPE_DLY < 0 || PIPE_DLY > 7) begin : g_bad_dly
    $error("mtl_scan_timing: PIPE_DLY must be 0..7");
  end

  localparam logic [X_W-1:0] X_LAST   = X_W'(H_TOTAL - 1);
  localparam logic [X_W-1:0] X_VIS    = X_W'(H_ACTIVE);
  localparam logic [X_W-1:0] HS_FIRST = X_W'(H_ACTIVE + H_FP);
  localparam logic [X_W-1:0] HS_LAST  = X_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [Y_W-1:0] Y_LAST   = Y_W'(V_TOTAL - 1);
  localparam logic [Y_W-1:0] Y_VIS    = Y_W'(V_ACTIVE);
  localparam logic [Y_W-1:0] VS_FIRST = Y_W'(V_ACTIVE + V_FP);
  localparam logic [Y_W-1:0] VS_LAST  = Y_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  sync_t          raw, dly;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (bus.en) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  always_comb begin
    raw.de   = (x_q < X_VIS) && (y_q < Y_VIS);
    raw.hs_n = !((x_q >= HS_FIRST) && (x_q <= HS_LAST));
    raw.vs_n = !((y_q >= VS_FIRST) && (y_q <= VS_LAST));
  end

  // Strobes are retimed; coordinates and start flags stay undelayed.
  if (PIPE_DLY == 0) begin : g_bypass
    assign dly = raw;
  end else begin : g_pipe
    sync_delay #(.DEPTH(PIPE_DLY)) u_dly (
      .clk    (clk),
      .reset  (reset),
      .en_i   (bus.en),
      .din_i  (raw),
      .dout_o (dly)
    );
  end

  assign bus.x_cnt       = x_q;
  assign bus.y_cnt       = y_q;
  assign bus.line_start  = (x_q == '0);
  assign bus.frame_start = (x_q == '0) && (y_q == '0);
  assign bus.hsync_n     = dly.hs_n;
  assign bus.vsync_n     = dly.vs_n;
  assign bus.de          = dly.de;

endmodule

// File: tb/tb_mtl_scan_timing.sv
// Directed bench: default panel for line-level timing, a shrunken 17x11
// raster for frame-level counts and strobe delay comparisons.
module tb_mtl_scan_timing;
  import mtl_timing_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic en = 1'b0;

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  int hs_low, hs_first, de_hi, vs_low, vs_first_x, vs_first_y, fs_cnt;
  int mx, my;
  logic prev_hs, prev_de;

  mtl_scan_if if_full ();
  mtl_scan_if if_s1 ();
  mtl_scan_if if_s0 ();
  mtl_scan_if if_s3 ();

  assign if_full.en = en;
  assign if_s1.en   = en;
  assign if_s0.en   = en;
  assign if_s3.en   = en;

  mtl_scan_timing u_full (.clk(clk), .reset(reset), .bus(if_full));

  mtl_scan_timing #(.H_ACTIVE(8), .H_FP(4), .H_SYNC(3), .H_BP(2),
                    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(1),
                    .PIPE_DLY(1)) u_s1 (.clk(clk), .reset(reset), .bus(if_s1));

  mtl_scan_timing #(.H_ACTIVE(8), .H_FP(4), .H_SYNC(3), .H_BP(2),
                    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(1),
                    .PIPE_DLY(0)) u_s0 (.clk(clk), .reset(reset), .bus(if_s0));

  mtl_scan_timing #(.H_ACTIVE(8), .H_FP(4), .H_SYNC(3), .H_BP(2),
                    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(1),
                    .PIPE_DLY(3)) u_s3 (.clk(clk), .reset(reset), .bus(if_s3));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    en    = 1'b0;
    repeat (2) step();
    reset = 1'b0;
  endtask

  initial begin
    // Reset state
    reset = 1'b1;
    en    = 1'b0;
    repeat (3) step();
    chk("rst_x",    if_full.x_cnt, 0);
    chk("rst_y",    if_full.y_cnt, 0);
    chk("rst_hs",   if_full.hsync_n, 1);
    chk("rst_vs",   if_full.vsync_n, 1);
    chk("rst_de",   if_full.de, 0);
    chk("rst_ls",   if_full.line_start, 1);
    chk("rst_fs",   if_full.frame_start, 1);
    chk("rst_d3_de", if_s3.de, 0);
    chk("rst_d0_de", if_s0.de, 1);

    // One full default line with PIPE_DLY=1
    reset = 1'b0;
    en    = 1'b1;
    hs_low = 0; hs_first = -1; de_hi = 0;
    for (int k = 1; k <= 1056; k++) begin
      step();
      chk("line_x",  if_full.x_cnt, k % 1056);
      chk("line_ls", if_full.line_start, (k % 1056) == 0);
      if (!if_full.hsync_n) begin
        if (hs_first < 0) hs_first = int'(if_full.x_cnt);
        hs_low++;
      end
      if (if_full.de) de_hi++;
    end
    chk("line_y",        if_full.y_cnt, 1);
    chk("line_hs_low",   hs_low, 30);
    chk("line_hs_first", hs_first, 1011);
    chk("line_de_hi",    de_hi, 800);

    // Small raster: two frames, plus PIPE_DLY 0 vs 3 edges
    do_reset();
    chk("d0_de_k0", if_s0.de, 1);
    chk("d3_de_k0", if_s3.de, 0);
    en = 1'b1;
    hs_low = 0; hs_first = -1; de_hi = 0; vs_low = 0;
    vs_first_x = -1; vs_first_y = -1; fs_cnt = 0;
    for (int k = 1; k <= 374; k++) begin
      step();
      if (k <= 2)  chk("d3_de_early", if_s3.de, 0);
      if (k == 3)  chk("d3_de_rise",  if_s3.de, 1);
      if (k == 10) chk("d3_de_last",  if_s3.de, 1);
      if (k == 11) chk("d3_de_fall",  if_s3.de, 0);
      if (k == 7)  chk("d0_de_last",  if_s0.de, 1);
      if (k == 8)  chk("d0_de_fall",  if_s0.de, 0);
      if (!if_s1.hsync_n) begin
        if (hs_first < 0) hs_first = int'(if_s1.x_cnt);
        hs_low++;
      end
      if (!if_s1.vsync_n) begin
        if (vs_first_x < 0) begin
          vs_first_x = int'(if_s1.x_cnt);
          vs_first_y = int'(if_s1.y_cnt);
        end
        vs_low++;
      end
      if (if_s1.de) de_hi++;
      if (if_s1.frame_start) fs_cnt++;
    end
    chk("frm_x_wrap",   if_s1.x_cnt, 0);
    chk("frm_y_wrap",   if_s1.y_cnt, 0);
    chk("frm_de_hi",    de_hi, 96);
    chk("frm_hs_low",   hs_low, 66);
    chk("frm_hs_first", hs_first, 13);
    chk("frm_vs_low",   vs_low, 68);
    chk("frm_vs_x",     vs_first_x, 1);
    chk("frm_vs_y",     vs_first_y, 8);
    chk("frm_fs_cnt",   fs_cnt, 2);

    // Enable toggled every clock across a line end
    do_reset();
    en = 1'b1;
    repeat (1050) step();
    chk("tog_start_x", if_full.x_cnt, 1050);
    mx = 1050; my = 0;
    for (int i = 0; i < 20; i++) begin
      en = (i % 2 == 1);
      prev_hs = if_full.hsync_n;
      prev_de = if_full.de;
      step();
      if (en) begin
        if (mx == 1055) begin
          mx = 0;
          my = my + 1;
        end else begin
          mx = mx + 1;
        end
      end else begin
        chk("tog_hs_hold", if_full.hsync_n, prev_hs);
        chk("tog_de_hold", if_full.de, prev_de);
      end
      chk("tog_x", if_full.x_cnt, mx);
      chk("tog_y", if_full.y_cnt, my);
    end
    chk("tog_end_x", if_full.x_cnt, 4);
    chk("tog_end_y", if_full.y_cnt, 1);

    // Asynchronous reset mid-line
    do_reset();
    en = 1'b1;
    repeat (500) step();
    chk("ar_pre_x",  if_full.x_cnt, 500);
    chk("ar_pre_de", if_full.de, 1);
    #1;
    reset = 1'b1;
    #1;
    chk("ar_x",    if_full.x_cnt, 0);
    chk("ar_y",    if_full.y_cnt, 0);
    chk("ar_hs",   if_full.hsync_n, 1);
    chk("ar_vs",   if_full.vsync_n, 1);
    chk("ar_de",   if_full.de, 0);
    chk("ar_s1_x", if_s1.x_cnt, 0);
    repeat (3) step();
    chk("ar_hold_x", if_full.x_cnt, 0);
    reset = 1'b0;
    step();
    chk("ar_rel_x1", if_full.x_cnt, 1);
    step();
    chk("ar_rel_x2", if_full.x_cnt, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
